// File: rtl/hovalaag_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : hovalaag_pkg                                             |
// | Description : Shared frame layout, field offsets and sync state type   |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
package hovalaag_pkg;

   localparam int PHASES  = 10;
   localparam int IN_W    = 6;
   localparam int FRAME_W = PHASES * IN_W;

   localparam int INSTR_LSB = 0;
   localparam int IN1_LSB   = 32;
   localparam int IN2_LSB   = 44;
   localparam int FLAG_LSB  = 56;

   typedef enum logic [0:0] {
      ST_HUNT = 1'b0,
      ST_LOCK = 1'b1
   } sync_state_e;

   // First member lands in the MSBs, so instr occupies frame bits [31:0].
   typedef struct packed {
      logic        run;
      logic        out_rd;
      logic        in2_wr;
      logic        in1_wr;
      logic [11:0] in2;
      logic [11:0] in1;
      logic [31:0] instr;
   } hv_frame_t;

endpackage
`default_nettype wire

// File: rtl/hovalaag_phase_checker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : hovalaag_phase_checker                                   |
// | Description : Tracks expected phase, lock state and sequence errors    |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module hovalaag_phase_checker
   import hovalaag_pkg::*;
#(
   parameter int N_PHASES = 10,
   parameter int PW       = $clog2(N_PHASES)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [N_PHASES-1:0] addr,
   output logic                capture_en,
   output logic [PW-1:0]       cap_ph,
   output logic                frame_done,
   output logic                sync_err
);

   sync_state_e   state_q, state_d;
   logic [PW-1:0] exp_ph_q, exp_ph_d;
   logic          w_ph0, w_match, w_last;

   // A non-one-hot addr can never equal a shifted single bit, so it falls into the error path.
   assign w_ph0   = (addr == N_PHASES'(1));
   assign w_match = (addr == (N_PHASES'(1) << exp_ph_q));
   assign w_last  = (exp_ph_q == PW'(N_PHASES - 1));

   always_comb begin
      state_d    = state_q;
      exp_ph_d   = exp_ph_q;
      capture_en = 1'b0;
      cap_ph     = exp_ph_q;
      frame_done = 1'b0;
      sync_err   = 1'b0;
      case (state_q)
         ST_HUNT: begin
            if (w_ph0) begin
               state_d    = ST_LOCK;
               exp_ph_d   = PW'(1);
               capture_en = 1'b1;
               cap_ph     = '0;
            end
         end
         ST_LOCK: begin
            if (w_match) begin
               capture_en = 1'b1;
               frame_done = w_last;
               exp_ph_d   = w_last ? '0 : exp_ph_q + 1'b1;
            end else begin
               sync_err = 1'b1;
               if (w_ph0) begin
                  exp_ph_d   = PW'(1);
                  capture_en = 1'b1;
                  cap_ph     = '0;
               end else begin
                  state_d  = ST_HUNT;
                  exp_ph_d = '0;
               end
            end
         end
         default: begin
            state_d  = ST_HUNT;
            exp_ph_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_HUNT;
         exp_ph_q <= '0;
      end else begin
         state_q  <= state_d;
         exp_ph_q <= exp_ph_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hovalaag_frame_deserializer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : hovalaag_frame_deserializer                              |
// | Description : Assembles 10-phase pad data into Hovalaag core frames    |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module hovalaag_frame_deserializer #(
   parameter int PHASES = 10,
   parameter int IN_W   = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [PHASES-1:0] addr,
   input  logic [IN_W-1:0]   in_data,
   output logic [31:0]       instr,
   output logic [11:0]       in1_data,
   output logic [11:0]       in2_data,
   output logic              in1_wr,
   output logic              in2_wr,
   output logic              out_rd,
   output logic              run,
   output logic              frame_valid,
   output logic              sync_err,
   output logic [7:0]        frames_ok
);
   import hovalaag_pkg::*;

   localparam int PW = $clog2(PHASES);

   logic                         w_capture_en, w_frame_done, w_sync_err;
   logic [PW-1:0]                w_cap_ph;
   logic [PHASES-1:0][IN_W-1:0]  frame_q, frame_d;
   hv_frame_t                    w_full, fields_q;
   logic                         valid_q, err_q;
   logic [7:0]                   ok_q;

   hovalaag_phase_checker #(
      .N_PHASES (PHASES),
      .PW       (PW)
   ) u_phase_checker (
      .clk        (clk),
      .reset_n    (reset_n),
      .addr       (addr),
      .capture_en (w_capture_en),
      .cap_ph     (w_cap_ph),
      .frame_done (w_frame_done),
      .sync_err   (w_sync_err)
   );

   always_comb begin
      frame_d = frame_q;
      if (w_capture_en) begin
         frame_d[w_cap_ph] = in_data;
      end
   end

   // Taken from the next-state view so the phase-9 slice is included, giving latency 1.
   assign w_full = hv_frame_t'(frame_d);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_q  <= '0;
         fields_q <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         ok_q     <= '0;
      end else begin
         frame_q <= frame_d;
         valid_q <= w_frame_done;
         err_q   <= w_sync_err;
         if (w_frame_done) begin
            fields_q <= w_full;
            ok_q     <= ok_q + 8'd1;
         end
      end
   end

   assign instr       = fields_q.instr;
   assign in1_data    = fields_q.in1;
   assign in2_data    = fields_q.in2;
   assign in1_wr      = fields_q.in1_wr;
   assign in2_wr      = fields_q.in2_wr;
   assign out_rd      = fields_q.out_rd;
   assign run         = fields_q.run;
   assign frame_valid = valid_q;
   assign sync_err    = err_q;
   assign frames_ok   = ok_q;

endmodule
`default_nettype wire

// File: tb/tb_hovalaag_frame_deserializer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_hovalaag_frame_deserializer                           |
// | Description : Randomised bench with a queue-based frame model          |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module tb_hovalaag_frame_deserializer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  addr;
   logic [5:0]  in_data;
   logic [31:0] instr;
   logic [11:0] in1_data, in2_data;
   logic        in1_wr, in2_wr, out_rd, run;
   logic        frame_valid, sync_err;
   logic [7:0]  frames_ok;

   int total = 0;
   int bad   = 0;

   // Model: captured slices of the current frame live in a queue; its size is the expected phase.
   bit          m_sync;
   logic [5:0]  m_q[$];
   logic [59:0] m_frame;
   bit          m_valid, m_err;
   logic [7:0]  m_ok;

   always #5 clk = ~clk;

   hovalaag_frame_deserializer #(
      .PHASES (10),
      .IN_W   (6)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .addr        (addr),
      .in_data     (in_data),
      .instr       (instr),
      .in1_data    (in1_data),
      .in2_data    (in2_data),
      .in1_wr      (in1_wr),
      .in2_wr      (in2_wr),
      .out_rd      (out_rd),
      .run         (run),
      .frame_valid (frame_valid),
      .sync_err    (sync_err),
      .frames_ok   (frames_ok)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model(input bit rn, input logic [9:0] a, input logic [5:0] d);
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!rn) begin
         m_sync  = 1'b0;
         m_q.delete();
         m_frame = '0;
         m_ok    = '0;
      end else if (!m_sync) begin
         if (a == 10'd1) begin
            m_sync = 1'b1;
            m_q    = {d};
         end
      end else if (a == (10'd1 << m_q.size())) begin
         m_q.push_back(d);
         if (m_q.size() == 10) begin
            for (int k = 0; k < 10; k++) m_frame[6*k +: 6] = m_q[k];
            m_valid = 1'b1;
            m_ok    = m_ok + 8'd1;
            m_q.delete();
         end
      end else begin
         m_err = 1'b1;
         if (a == 10'd1) begin
            m_q = {d};
         end else begin
            m_sync = 1'b0;
            m_q.delete();
         end
      end
   endtask

   task automatic step(input bit rn, input logic [9:0] a, input logic [5:0] d);
      reset_n = rn;
      addr    = a;
      in_data = d;
      @(posedge clk);
      model(rn, a, d);
      #1;
      check("frame_valid", {63'd0, frame_valid}, {63'd0, m_valid});
      check("sync_err", {63'd0, sync_err}, {63'd0, m_err});
      check("frames_ok", {56'd0, frames_ok}, {56'd0, m_ok});
      check("frame_fields", {4'd0, run, out_rd, in2_wr, in1_wr, in2_data, in1_data, instr},
            {4'd0, m_frame});
   endtask

   task automatic phases(input int first, input int last, input bit use_idx);
      for (int k = first; k <= last; k++)
         step(1'b1, 10'd1 << k, use_idx ? 6'(k) : 6'($urandom_range(0, 63)));
   endtask

   initial begin
      reset_n = 1'b0;
      addr    = '0;
      in_data = '0;
      step(1'b0, 10'd0, 6'd0);
      step(1'b0, 10'd1, 6'd5);

      // Indexed frame: slice k carries value k.
      phases(0, 9, 1'b1);
      check("lit_model_frame", {4'd0, m_frame}, 64'h02481C61440C2040);
      check("lit_instr", {32'd0, instr}, 64'h440C2040);
      check("lit_in1", {52'd0, in1_data}, 64'hC61);
      check("lit_in2", {52'd0, in2_data}, 64'h481);
      check("lit_flags", {60'd0, run, out_rd, in2_wr, in1_wr}, 64'h2);
      check("lit_frames_ok", {56'd0, frames_ok}, 64'd1);

      // Join mid-stream at phase 3.
      step(1'b0, 10'd0, 6'd0);
      phases(3, 9, 1'b0);
      phases(0, 9, 1'b0);

      // Phase skip 4 -> 6, then a good frame.
      phases(0, 4, 1'b0);
      step(1'b1, 10'd1 << 6, 6'h2A);
      phases(0, 9, 1'b0);

      // Address-reset at expected phase 5.
      phases(0, 4, 1'b0);
      phases(0, 9, 1'b1);
      check("lit_resync_instr", {32'd0, instr}, 64'h440C2040);

      // Zero and multi-hot addr while locked.
      phases(0, 2, 1'b0);
      step(1'b1, 10'd0, 6'h11);
      step(1'b1, 10'b0000000011, 6'h22);

      // Reset colliding with phase-9 completion.
      phases(0, 8, 1'b0);
      step(1'b0, 10'd1 << 9, 6'h3F);
      check("lit_reset_wins", {63'd0, frame_valid}, 64'd0);

      // Reset at phase 7, then 256 frames to wrap the counter.
      phases(0, 6, 1'b0);
      step(1'b0, 10'd1 << 7, 6'h07);
      for (int f = 0; f < 256; f++) phases(0, 9, 1'b0);
      check("lit_wrap", {56'd0, frames_ok}, 64'd0);

      // Randomised mix of good phases, misordered phases, junk addr and resets.
      for (int i = 0; i < 2500; i++) begin
         int         nxt;
         int         r;
         logic [9:0] a;
         nxt = m_sync ? m_q.size() : 0;
         r   = $urandom_range(0, 99);
         if (r < 86)      a = 10'd1 << nxt;
         else if (r < 93) a = 10'd1 << $urandom_range(0, 9);
         else             a = 10'($urandom_range(0, 1023));
         step(r != 99, a, 6'($urandom_range(0, 63)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
